// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared constants and types for the AES-256 key-schedule slice:
//   data widths, the round-constant table, the S-box table and the
//   key-schedule controller state type.
package aes_pkg;

  localparam int AES_256_KEY_W = 256;
  localparam int AES_HALFKEY_W = 128;
  localparam int AES_WORD_W    = 32;

  // Rcon[i] sits in the most significant byte of the word it is XORed into.
  localparam logic [7:0] AES_RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  localparam logic [7:0] AES_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {KS_IDLE, KS_EMIT} ks_state_e;

  // Round constant for even round r, looked up with r/2; index 0 has no constant.
  function automatic logic [7:0] rcon_byte(input logic [2:0] i);
    logic [7:0] r;
    r = 8'h00;
    if (i != 3'd0) r = AES_RCON[i];
    return r;
  endfunction

endpackage

// File: rtl/aes256_key_expansion_step.sv
// aes256_key_expansion_step
//   Purely combinational AES-256 half-key step: produces the next 128-bit
//   round key from the two previous ones.
//   old_halfkey : round key r-2 (words W1..W4, W1 is the MSW)
//   halfkey     : round key r-1 (its W4 feeds the transform)
//   round       : index r of the key being produced (2..14)
//   new_halfkey : round key r
module aes256_key_expansion_step
  import aes_pkg::*;
(
  input  logic [AES_HALFKEY_W-1:0] old_halfkey,
  input  logic [AES_HALFKEY_W-1:0] halfkey,
  input  logic [3:0]               round,
  output logic [AES_HALFKEY_W-1:0] new_halfkey
);

  logic [AES_WORD_W-1:0] last_word;
  logic [AES_WORD_W-1:0] sbox_word;
  logic [AES_WORD_W-1:0] subst_word;
  logic [AES_WORD_W-1:0] t_word;
  logic [AES_WORD_W-1:0] w1, w2, w3, w4;
  logic                  even_round;
  logic [7:0]            rcon;

  assign last_word  = halfkey[AES_WORD_W-1:0];
  assign even_round = ~round[0];

  // Even rounds rotate the word left by one byte before substitution.
  assign sbox_word = even_round ? {last_word[23:0], last_word[31:24]} : last_word;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .sel_byte (sbox_word[8*g +: 8]),
      .sub_byte (subst_word[8*g +: 8])
    );
  end

  assign rcon   = even_round ? rcon_byte(round[3:1]) : 8'h00;
  assign t_word = subst_word ^ {rcon, 24'h000000};

  // Each new word chains on the freshly produced previous word.
  assign w1 = old_halfkey[127:96] ^ t_word;
  assign w2 = old_halfkey[95:64]  ^ w1;
  assign w3 = old_halfkey[63:32]  ^ w2;
  assign w4 = old_halfkey[31:0]   ^ w3;

  assign new_halfkey = {w1, w2, w3, w4};

endmodule

// File: rtl/aes_sbox.sv
// aes_sbox
//   Combinational AES forward S-box (table lookup).
//   sel_byte : byte to substitute
//   sub_byte : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] sel_byte,
  output logic [7:0] sub_byte
);

  assign sub_byte = AES_SBOX[sel_byte];

endmodule

// File: rtl/aes256_key_schedule_ctrl.sv
// aes256_key_schedule_ctrl
//   Iterative AES-256 key-schedule sequencer. Accepts a 256-bit key and
//   streams RK0..RK14 over valid/ready, one half-key step per beat. The key
//   is retained so replay_req regenerates the sequence without reloading.
//
//   Handshake: a round key transfers on a cycle where rk_valid && rk_ready
//   at the rising edge. While rk_valid is high and rk_ready low, rk_data,
//   rk_idx and rk_last hold stable. A key is taken when key_valid is high
//   and key_ready (IDLE) is high at the rising edge.
//
//   Ports: clk, rst_n (async active-low); key_valid/key_ready/key (key load);
//   replay_req (restart from stored key); abort (drop sequence);
//   key_loaded (stored key valid); rk_valid/rk_ready/rk_data/rk_idx/rk_last
//   (round-key stream).
module aes256_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_RKEYS = 15,
  parameter int IDX_W     = $clog2(NUM_RKEYS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_valid,
  output logic                     key_ready,
  input  logic [AES_256_KEY_W-1:0] key,
  input  logic                     replay_req,
  input  logic                     abort,
  output logic                     key_loaded,
  output logic                     rk_valid,
  input  logic                     rk_ready,
  output logic [AES_HALFKEY_W-1:0] rk_data,
  output logic [IDX_W-1:0]         rk_idx,
  output logic                     rk_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RKEYS - 1);

  ks_state_e               state, state_nxt;
  logic [AES_256_KEY_W-1:0] key_reg;
  logic [AES_HALFKEY_W-1:0] prev_hk;
  logic [AES_HALFKEY_W-1:0] cur_hk;
  logic [AES_HALFKEY_W-1:0] next_hk;
  logic [IDX_W-1:0]         idx;
  logic [3:0]               step_round;
  logic                     beat;
  logic                     idx_last;
  logic                     load_key;
  logic                     load_replay;
  logic                     advance;

  assign idx_last = (idx == LAST_IDX);
  assign beat     = (state == KS_EMIT) && rk_ready;

  // Abort suppresses every register update in the cycle it is seen, so it
  // beats both a same-cycle beat and a same-cycle load.
  assign load_key    = (state == KS_IDLE) && key_valid && !abort;
  assign load_replay = (state == KS_IDLE) && !key_valid && replay_req && key_loaded && !abort;
  assign advance     = beat && !abort;

  assign step_round = 4'(idx) + 4'd1;

  aes256_key_expansion_step u_step (
    .old_halfkey (prev_hk),
    .halfkey     (cur_hk),
    .round       (step_round),
    .new_halfkey (next_hk)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= KS_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      KS_IDLE: if (key_valid || (replay_req && key_loaded)) state_nxt = KS_EMIT;
      KS_EMIT: if (beat && idx_last)                        state_nxt = KS_IDLE;
      default: state_nxt = KS_IDLE;
    endcase
    if (abort) state_nxt = KS_IDLE;
  end

  // Output logic
  always_comb begin
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    rk_data   = '0;
    rk_idx    = '0;
    rk_last   = 1'b0;
    unique case (state)
      KS_IDLE: key_ready = 1'b1;
      KS_EMIT: begin
        rk_valid = 1'b1;
        // RK0 is the upper key half and is only ever in prev_hk; from idx 1
        // on the key being presented is always the newest half-key.
        rk_data  = (idx == '0) ? prev_hk : cur_hk;
        rk_idx   = idx;
        rk_last  = idx_last;
      end
      default: ;
    endcase
  end

  // Datapath: key store, half-key pair and round index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      prev_hk    <= '0;
      cur_hk     <= '0;
      idx        <= '0;
      key_loaded <= 1'b0;
    end else if (load_key) begin
      key_reg    <= key;
      prev_hk    <= key[255:128];
      cur_hk     <= key[127:0];
      idx        <= '0;
      key_loaded <= 1'b1;
    end else if (load_replay) begin
      prev_hk <= key_reg[255:128];
      cur_hk  <= key_reg[127:0];
      idx     <= '0;
    end else if (advance) begin
      if (idx == '0) begin
        // RK1 is already in cur_hk; only move the index.
        idx <= IDX_W'(1);
      end else if (!idx_last) begin
        prev_hk <= cur_hk;
        cur_hk  <= next_hk;
        idx     <= idx + IDX_W'(1);
      end
    end
  end

  // idx stays within 0..NUM_RKEYS-1, and the sequencer is built for AES-256 only.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (NUM_RKEYS == 15);
      assert (idx <= LAST_IDX);
    end
  end

endmodule

// File: tb/tb_aes256_key_schedule_ctrl.sv
module tb_aes256_key_schedule_ctrl;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
  logic         replay_req;
  logic         abort;
  logic         key_loaded;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;

  aes256_key_schedule_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .replay_req (replay_req),
    .abort      (abort),
    .key_loaded (key_loaded),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_idx     (rk_idx),
    .rk_last    (rk_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [132:0] exp_q[$];
  logic [127:0] seen_rk [16];
  logic         rand_ready = 1'b0;
  logic [255:0] model_key;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] FIPS_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] FIPS_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // S-box built from GF(2^8) inversion plus the affine map, and the key
  // expansion written as the textbook 60-word recurrence.
  logic [7:0]   sbox_ref [256];
  logic [127:0] ref_rk [15];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
      end
      b = inv;
      sbox_ref[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_expected(input logic [255:0] k);
    ref_expand(k);
    for (int r = 0; r < 15; r++) exp_q.push_back({4'(r), (r == 14), ref_rk[r]});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [132:0] act, held, e;
    logic         stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      act = {rk_idx, rk_last, rk_data};
      if (rk_valid) begin
        if (stalled) chk("stall_hold", 256'(act), 256'(held));
        if (rk_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat actual idx=%0d data=%h required none", rk_idx, rk_data);
          end else begin
            e = exp_q.pop_front();
            chk("rk_beat", 256'(act), 256'(e));
          end
          seen_rk[rk_idx] = rk_data;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = act;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Random backpressure, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) rk_ready = ($urandom_range(0, 2) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic start_key(input logic [255:0] k);
    key       = k;
    key_valid = 1'b1;
    model_key = k;
    push_expected(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic do_replay();
    replay_req = 1'b1;
    push_expected(model_key);
    @(posedge clk); #1;
    replay_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(key_ready && exp_q.size() == 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_idx(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (!(rk_valid && rk_idx == target) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual idx=%0d required %0d", name, rk_idx, target);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_key_ready"},  256'(key_ready),  256'(1));
    chk({name, "_key_loaded"}, 256'(key_loaded), 256'(0));
    chk({name, "_rk_valid"},   256'(rk_valid),   256'(0));
    chk({name, "_rk_data"},    256'(rk_data),    256'(0));
    chk({name, "_rk_idx"},     256'(rk_idx),     256'(0));
    chk({name, "_rk_last"},    256'(rk_last),    256'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cycles_valid;
    logic [255:0] k2;

    rst_n      = 1'b0;
    key_valid  = 1'b0;
    key        = '0;
    replay_req = 1'b0;
    abort      = 1'b0;
    rk_ready   = 1'b0;
    model_key  = '0;
    build_sbox();

    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // replay with nothing loaded is ignored
    replay_req = 1'b1;
    @(posedge clk); #1;
    replay_req = 1'b0;
    repeat (3) begin
      chk("replay_unloaded_valid", 256'(rk_valid), 256'(0));
      @(posedge clk); #1;
    end

    // 1: FIPS-197 key, full throughput
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    chk("rk0_latency_valid", 256'(rk_valid), 256'(1));
    chk("key_loaded_set", 256'(key_loaded), 256'(1));
    cycles_valid = 1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!rk_valid) break;
      cycles_valid++;
    end
    chk("consecutive_beats", 256'(cycles_valid), 256'(15));
    chk("key_ready_after_last", 256'(key_ready), 256'(1));
    wait_idle("fips");
    chk("fips_rk0",  256'(seen_rk[0]),  256'(FIPS_KEY[255:128]));
    chk("fips_rk1",  256'(seen_rk[1]),  256'(FIPS_KEY[127:0]));
    chk("fips_rk2",  256'(seen_rk[2]),  256'(FIPS_RK2));
    chk("fips_rk14", 256'(seen_rk[14]), 256'(FIPS_RK14));

    // 2: same key under random backpressure
    rand_ready = 1'b1;
    start_key(FIPS_KEY);
    wait_idle("fips_bp");

    // 3: replay from the stored key
    do_replay();
    wait_idle("replay");
    rand_ready = 1'b0;
    @(posedge clk); #1;
    rk_ready = 1'b1;

    // random keys, some replayed, random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      k2 = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      start_key(k2);
      wait_idle("rand_key");
      if ($urandom_range(0, 1) == 1) begin
        do_replay();
        wait_idle("rand_replay");
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    rk_ready = 1'b1;

    // 4: abort at idx 7 together with a beat
    start_key(FIPS_KEY);
    wait_idx(4'd7, "abort_wait");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    chk("abort_rk_valid", 256'(rk_valid), 256'(0));
    chk("abort_key_ready", 256'(key_ready), 256'(1));
    chk("abort_key_loaded", 256'(key_loaded), 256'(1));
    @(posedge clk); #1;
    chk("abort_no_idx8", 256'(rk_valid), 256'(0));
    do_replay();
    chk("abort_replay_idx", 256'(rk_idx), 256'(0));
    chk("abort_replay_rk0", 256'(rk_data), 256'(FIPS_KEY[255:128]));
    wait_idle("abort_replay");

    // 5: new key and replay in the same cycle, new key wins
    k2 = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    key        = k2;
    key_valid  = 1'b1;
    replay_req = 1'b1;
    model_key  = k2;
    push_expected(k2);
    @(posedge clk); #1;
    key_valid  = 1'b0;
    replay_req = 1'b0;
    chk("collide_rk0", 256'(rk_data), 256'(k2[255:128]));
    wait_idle("collide");

    // 6: reset mid-sequence
    start_key(FIPS_KEY);
    wait_idx(4'd10, "reset_wait");
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_outputs("midreset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    replay_req = 1'b1;
    @(posedge clk); #1;
    replay_req = 1'b0;
    repeat (3) begin
      chk("post_reset_replay_valid", 256'(rk_valid), 256'(0));
      chk("post_reset_key_ready", 256'(key_ready), 256'(1));
      @(posedge clk); #1;
    end

    chk("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
